// File: rtl/bin2bcd_display.sv
// rtl/bin2bcd_display.sv - sequential double-dabble binary to 8-digit packed BCD converter
// Optional free-running mode: define BIN2BCD_AUTO_EN.
module bin2bcd_display #(
    parameter int BIN_WIDTH = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_WIDTH-1:0] bin_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          bcd_out,
    output logic                 overflow
);

    localparam logic [32:0] BCD_MAX   = 33'd99_999_999;
    localparam logic [4:0]  CNT_LOAD  = 5'(BIN_WIDTH - 1);
    localparam logic [31:0] BCD_SATUR = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FINISH
    } state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] sh;
    logic [31:0]          acc;
    logic [31:0]          acc_adj;
    logic [4:0]           cnt;
    logic                 ovf_q;
    logic                 launch;
    logic                 in_ovf;

`ifdef BIN2BCD_AUTO_EN
    logic unused_start;
    assign unused_start = start;
    assign launch       = 1'b1;
`else
    assign launch = start;
`endif

    // Zero-extended compare folds to constant 0 for narrow inputs.
    assign in_ovf = (33'(bin_in) > BCD_MAX);

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        sh    <= bin_in;
                        acc   <= '0;
                        cnt   <= CNT_LOAD;
                        ovf_q <= in_ovf;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc <= {acc_adj[30:0], sh[BIN_WIDTH-1]};
                    sh  <= sh << 1;
                    if (cnt == 5'd0) begin
                        state <= FINISH;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                FINISH: begin
                    bcd_out  <= ovf_q ? BCD_SATUR : acc;
                    overflow <= ovf_q;
                    done     <= 1'b1;
                    // Relaunching here keeps back-to-back conversions at BIN_WIDTH+1 clocks.
                    if (launch) begin
                        sh    <= bin_in;
                        acc   <= '0;
                        cnt   <= CNT_LOAD;
                        ovf_q <= in_ovf;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
